// File: rtl/stage_sequencer_pkg.sv
// seq_pkg: shared types and helpers for the stage sequencer.
//   state_e      - sequencer FSM states
//   pick_t       - result of a stage search (found flag + stage index)
//   next_enabled - lowest set bit of a stage mask at or above a start index
package seq_pkg;

    localparam int MAX_STAGES = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_NEXT,
        S_FINISH,
        S_ERROR
    } state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // 'from' is one bit wider than an index so that "above the last stage"
    // (cur_stage + 1 == MAX_STAGES) is representable and simply finds nothing.
    function automatic pick_t next_enabled(input logic [MAX_STAGES-1:0] mask,
                                           input logic [4:0]            from);
        pick_t p;
        p = '0;
        // Scan downwards so the last hit written is the lowest qualifying index.
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= from)) begin
                p.found = 1'b1;
                p.idx   = 4'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/stage_sequencer_watchdog.sv
// stage_watchdog: counts RUN cycles of the active stage.
//   clk, rst - clock, synchronous active-high reset
//   clear    - restart the count (stage launch)
//   run      - stage is running this cycle
//   expired  - this is the TIMEOUT_CYCLES-th consecutive run cycle
// TIMEOUT_CYCLES = 0 removes the counter and never expires.
module stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clear, run};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Count holds at LAST so a stalled 'run' can never wrap around.
            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (run && (cnt_q != LAST)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired = run && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: runs the enabled engines one after another, muxing the
// active engine's memory port onto the shared image memories.
//   go/abort/stage_en            - sequence control and per-run enable mask
//   stage_start/stage_done       - one-hot launch pulse / completion per engine
//   stage_rd_*/stage_wr_*        - flattened per-engine memory requests
//   mem_rd_*/mem_wr_*, rd_data   - shared memory side; rd_data is registered
//   busy/done/error/err_stage    - status; err_stage names the timed-out stage
//   cur_stage/run_cycles         - active stage, saturating cycle count of the run
module stage_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int STAGE_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic                         abort,
    input  logic [NUM_STAGES-1:0]        stage_en,
    output logic [NUM_STAGES-1:0]        stage_start,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_rd_addr,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_wr_addr,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_wr_data,
    input  logic [NUM_STAGES-1:0]        stage_wr_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic [ADDR_W-1:0]            mem_rd_addr,
    input  logic [DATA_W-1:0]            mem_rd_data,
    output logic [ADDR_W-1:0]            mem_wr_addr,
    output logic [DATA_W-1:0]            mem_wr_data,
    output logic                         mem_wr_en,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [STAGE_W-1:0]           err_stage,
    output logic [STAGE_W-1:0]           cur_stage,
    output logic [31:0]                  run_cycles
);

    import seq_pkg::*;

    state_e                state_q, state_d;
    logic [NUM_STAGES-1:0] mask_q, mask_d;
    logic [STAGE_W-1:0]    cur_stage_q, cur_stage_d;
    logic [STAGE_W-1:0]    err_stage_q, err_stage_d;
    logic [31:0]           run_cycles_q, run_cycles_d;
    logic [DATA_W-1:0]     rd_data_q;
    logic                  wd_clear, wd_run, wd_expired;
    pick_t                 first_pick, next_pick;

    logic [ADDR_W-1:0] rd_addr_a [NUM_STAGES];
    logic [ADDR_W-1:0] wr_addr_a [NUM_STAGES];
    logic [DATA_W-1:0] wr_data_a [NUM_STAGES];

    generate
        for (genvar g = 0; g < NUM_STAGES; g++) begin : g_unpack
            assign rd_addr_a[g] = stage_rd_addr[g*ADDR_W +: ADDR_W];
            assign wr_addr_a[g] = stage_wr_addr[g*ADDR_W +: ADDR_W];
            assign wr_data_a[g] = stage_wr_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    // First stage comes from the live mask (it is latched on the same edge);
    // later stages come from the latched copy.
    assign first_pick = next_enabled(16'(stage_en), 5'd0);
    assign next_pick  = next_enabled(16'(mask_q), 5'(cur_stage_q) + 5'd1);

    assign busy     = (state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_NEXT);
    assign done     = (state_q == S_FINISH);
    assign error    = (state_q == S_ERROR);
    assign wd_clear = (state_q == S_LAUNCH);
    assign wd_run   = (state_q == S_RUN);

    stage_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .run     (wd_run),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        cur_stage_d  = cur_stage_q;
        err_stage_d  = err_stage_q;
        run_cycles_d = run_cycles_q;

        if (busy && (run_cycles_q != '1)) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end

        case (state_q)
            S_IDLE, S_FINISH, S_ERROR: begin
                if (go) begin
                    mask_d       = stage_en;
                    run_cycles_d = '0;
                    if (first_pick.found) begin
                        cur_stage_d = STAGE_W'(first_pick.idx);
                        state_d     = S_LAUNCH;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_LAUNCH: state_d = S_RUN;
            S_RUN: begin
                // Done beats a same-cycle timeout.
                if (stage_done[cur_stage_q]) begin
                    state_d = S_NEXT;
                end else if (wd_expired) begin
                    state_d     = S_ERROR;
                    err_stage_d = cur_stage_q;
                end
            end
            S_NEXT: begin
                if (next_pick.found) begin
                    cur_stage_d = STAGE_W'(next_pick.idx);
                    state_d     = S_LAUNCH;
                end else begin
                    state_d = S_FINISH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over go and freezes everything except the state.
        if (abort) begin
            state_d      = S_IDLE;
            mask_d       = mask_q;
            cur_stage_d  = cur_stage_q;
            err_stage_d  = err_stage_q;
            run_cycles_d = run_cycles_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            cur_stage_q  <= '0;
            err_stage_q  <= '0;
            run_cycles_q <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            cur_stage_q  <= cur_stage_d;
            err_stage_q  <= err_stage_d;
            run_cycles_q <= run_cycles_d;
            rd_data_q    <= mem_rd_data;
        end
    end

    always_comb begin
        stage_start = '0;
        if ((state_q == S_LAUNCH) && !abort) begin
            stage_start[cur_stage_q] = 1'b1;
        end
    end

    assign mem_rd_addr = rd_addr_a[cur_stage_q];
    assign mem_wr_addr = wr_addr_a[cur_stage_q];
    assign mem_wr_data = wr_data_a[cur_stage_q];
    assign mem_wr_en   = wd_run & stage_wr_en[cur_stage_q];
    assign rd_data     = rd_data_q;
    assign err_stage   = err_stage_q;
    assign cur_stage   = cur_stage_q;
    assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: engine models drive stage_done after a programmed
// number of RUN cycles; expected start order, run length and outcome of each
// sequence are computed up front from the mask and latencies.
module tb_stage_sequencer;

    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int TO = 16;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, go, abort;
    logic [NS-1:0]     stage_en, stage_start, stage_done, stage_wr_en;
    logic [NS*AW-1:0]  stage_rd_addr, stage_wr_addr;
    logic [NS*DW-1:0]  stage_wr_data;
    logic [DW-1:0]     rd_data, mem_rd_data, mem_wr_data;
    logic [AW-1:0]     mem_rd_addr, mem_wr_addr;
    logic              mem_wr_en, busy, done, error;
    logic [SW-1:0]     err_stage, cur_stage;
    logic [31:0]       run_cycles;

    stage_sequencer #(
        .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .stage_en(stage_en),
        .stage_start(stage_start), .stage_done(stage_done),
        .stage_rd_addr(stage_rd_addr), .stage_wr_addr(stage_wr_addr),
        .stage_wr_data(stage_wr_data), .stage_wr_en(stage_wr_en),
        .rd_data(rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .busy(busy), .done(done), .error(error), .err_stage(err_stage),
        .cur_stage(cur_stage), .run_cycles(run_cycles)
    );

    int n_vec = 0;
    int n_err = 0;

    // Engine models: act = engine is in its RUN window, k = 1-based RUN cycle.
    bit  act [NS];
    int  k   [NS];
    int  lat [NS];   // 0 = never finishes
    int  exp_q [$];  // expected order of start pulses
    bit            dir_wr;
    logic [NS-1:0] extra_done;
    logic [DW-1:0] prev_rd;
    bit            rst_s;
    logic [NS-1:0] prev_start;

    logic          o_done, o_error, o_busy, o_wr_en;
    logic [SW-1:0] o_err_stage, o_cur_stage;
    logic [31:0]   o_rc;
    logic [DW-1:0] o_rd;
    logic [NS-1:0] o_start;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rand();
        for (int i = 0; i < NS; i++) begin
            stage_rd_addr[i*AW +: AW] = $urandom;
            stage_wr_addr[i*AW +: AW] = $urandom;
            stage_wr_data[i*DW +: DW] = DW'($urandom);
            stage_wr_en[i]            = 1'($urandom_range(0, 1));
            if (act[i]) stage_done[i] = (lat[i] != 0) && (k[i] == lat[i]);
            else        stage_done[i] = ($urandom_range(0, 3) == 0);
        end
        stage_done = stage_done | extra_done;
        if (dir_wr && act[0]) begin
            stage_wr_en[1:0]      = 2'b11;
            stage_wr_addr[0 +: AW] = 32'h10;
            stage_wr_data[0 +: DW] = 16'hABCD;
        end
        mem_rd_data = DW'($urandom);
    endtask

    task automatic tick();
        int a;
        logic [NS-1:0] drv_done;
        drive_rand();
        drv_done = stage_done;
        @(negedge clk);
        o_done = done; o_error = error; o_busy = busy; o_wr_en = mem_wr_en;
        o_err_stage = err_stage; o_cur_stage = cur_stage; o_rc = run_cycles;
        o_rd = rd_data; o_start = stage_start;
        a = -1;
        for (int i = 0; i < NS; i++) if (act[i]) a = i;
        chk("rd_data", rd_data, rst_s ? 64'd0 : 64'(prev_rd));
        if (a >= 0) begin
            chk("busy_in_run", busy, 1);
            chk("mem_rd_addr", mem_rd_addr, stage_rd_addr[a*AW +: AW]);
            chk("mem_wr_en", mem_wr_en, stage_wr_en[a]);
            if (stage_wr_en[a]) begin
                chk("mem_wr_addr", mem_wr_addr, stage_wr_addr[a*AW +: AW]);
                chk("mem_wr_data", mem_wr_data, stage_wr_data[a*DW +: DW]);
            end
        end else begin
            chk("mem_wr_en_idle", mem_wr_en, 0);
        end
        if (stage_start != '0) begin
            chk("start_onehot", $countones(stage_start), 1);
            chk("start_width", prev_start, 0);
            if (exp_q.size() == 0) chk("start_unexpected", stage_start, 0);
            else begin
                int e;
                e = exp_q.pop_front();
                chk("start_order", stage_start, 1 << e);
            end
        end
        prev_start = stage_start;
        @(posedge clk);
        prev_rd = mem_rd_data;
        rst_s   = rst;
        if (rst || abort) begin
            for (int i = 0; i < NS; i++) act[i] = 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (act[i]) begin
                    if (drv_done[i] || k[i] == TO) act[i] = 0;
                    else k[i]++;
                end
                if (o_start[i]) begin
                    act[i] = 1;
                    k[i]   = 1;
                end
            end
        end
        #1;
    endtask

    // Expected outcome: every enabled stage costs LAUNCH + latency + NEXT;
    // a stage that never finishes by RUN cycle TO costs LAUNCH + TO and ends the run.
    task automatic start_seq(input logic [2:0] m, input int l0, input int l1, input int l2,
                             output int exp_rc, output bit exp_err, output int exp_es);
        lat[0] = l0; lat[1] = l1; lat[2] = l2;
        exp_rc = 0; exp_err = 0; exp_es = 0;
        exp_q.delete();
        for (int i = 0; i < NS; i++) begin
            if (m[i] && !exp_err) begin
                exp_q.push_back(i);
                if (lat[i] == 0 || lat[i] > TO) begin
                    exp_rc += 1 + TO;
                    exp_err = 1;
                    exp_es  = i;
                end else begin
                    exp_rc += lat[i] + 2;
                end
            end
        end
        stage_en = m;
        go = 1;
        tick();
        go = 0;
        stage_en = 3'($urandom);  // must not matter once latched
    endtask

    task automatic run_seq(input logic [2:0] m, input int l0, input int l1, input int l2,
                           input bit noise);
        int rc, es, waited;
        bit er, fin;
        start_seq(m, l0, l1, l2, rc, er, es);
        waited = 0;
        fin = 0;
        while (!fin && waited < 400) begin
            go = noise && (act[0] || act[1] || act[2]) && ($urandom_range(0, 2) == 0);
            tick();
            waited++;
            fin = o_done || o_error;
        end
        go = 0;
        chk("seq_complete", fin, 1);
        chk("latency", waited, rc + 1);
        chk("done", o_done, !er);
        chk("error", o_error, er);
        if (er) chk("err_stage", o_err_stage, es);
        chk("run_cycles", o_rc, rc);
        chk("busy_end", o_busy, 0);
        chk("starts_left", exp_q.size(), 0);
    endtask

    initial begin
        int rc, es, waited;
        bit er;
        logic [31:0] rc_hold;
        rst = 1; go = 0; abort = 0; stage_en = '0; extra_done = '0; dir_wr = 0;
        prev_start = '0; rst_s = 1; prev_rd = '0;
        for (int i = 0; i < NS; i++) begin act[i] = 0; k[i] = 0; lat[i] = 0; end

        tick(); tick();
        chk("rst_done", o_done, 0);
        chk("rst_error", o_error, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err_stage", o_err_stage, 0);
        chk("rst_cur_stage", o_cur_stage, 0);
        chk("rst_run_cycles", o_rc, 0);
        chk("rst_rd_data", o_rd, 0);
        chk("rst_start", o_start, 0);
        chk("rst_wr_en", o_wr_en, 0);
        rst = 0;
        tick();

        dir_wr = 1;
        run_seq(3'b111, 5, 10, 7, 0);       // 28 cycles
        dir_wr = 0;
        run_seq(3'b101, 2, 6, 3, 0);        // back-to-back from FINISH, stage 1 skipped
        run_seq(3'b000, 1, 1, 1, 0);        // done one cycle after go
        run_seq(3'b111, 5, 0, 3, 0);        // stage 1 times out, err_stage 1, 24 cycles
        run_seq(3'b011, 16, 1, 9, 0);       // restart from ERROR; done on the timeout cycle

        // Abort during stage 1 RUN with a spurious done on stage 2.
        start_seq(3'b111, 3, 0, 4, rc, er, es);
        waited = 0;
        while (!(act[1] && k[1] == 3) && waited < 100) begin tick(); waited++; end
        chk("abort_reach", act[1] && k[1] == 3, 1);
        extra_done = 3'b100;
        abort = 1;
        tick();
        abort = 0;
        exp_q.delete();
        tick();
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_error", o_error, 0);
        chk("abort_start", o_start, 0);
        rc_hold = o_rc;
        tick(); tick();
        chk("abort_rc_hold", o_rc, rc_hold);
        chk("abort_idle", o_busy, 0);
        extra_done = '0;

        // Reset in the middle of stage 1 RUN.
        start_seq(3'b111, 4, 4, 4, rc, er, es);
        waited = 0;
        while (!act[1] && waited < 100) begin tick(); waited++; end
        chk("rst_reach", act[1], 1);
        rst = 1;
        tick();
        exp_q.delete();
        tick();
        chk("mid_rst_start", o_start, 0);
        chk("mid_rst_done", o_done, 0);
        chk("mid_rst_error", o_error, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_err_stage", o_err_stage, 0);
        chk("mid_rst_cur_stage", o_cur_stage, 0);
        chk("mid_rst_run_cycles", o_rc, 0);
        chk("mid_rst_rd_data", o_rd, 0);
        chk("mid_rst_wr_en", o_wr_en, 0);
        rst = 0;
        tick();

        for (int n = 0; n < 25; n++) begin
            int l [NS];
            for (int i = 0; i < NS; i++)
                l[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
            run_seq(3'($urandom), l[0], l[1], l[2], 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
